x_top_uart_loader: RTL and testbench

Byte-stream frame parser sitting directly downstream of the UART receiver. Consumes received bytes and decodes write and go commands. Write frames become 32-bit word writes on a valid/ready memory port. A go command releases the core run flag. Used to load a program image over UART before the rv32i core starts.

---
 rtl/x_top_uart_loader.sv | 197 +++++++++++++++++++
 tb/tb_x_top_uart_loader.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/x_top_uart_loader.sv
// x_top_uart_loader: byte-stream frame parser placed after the UART receiver.
// Frames: 'W' + 4 address bytes + 4 data bytes (both little-endian) turn into a
// single 32-bit write on a valid/ready memory port. A 'G' byte sets the sticky
// run flag. Protocol problems (unknown command, overrun, timeout, bad checksum)
// set the sticky error flag.
// Optional feature macro: X_TOP_UART_LOADER_CSUM_EN adds a trailing XOR
// checksum byte to each write frame.
module x_top_uart_loader #(
    parameter int p_timeout = 100000
) (
    input  logic        i_clk,
    input  logic        i_nrst,
    input  logic        i_valid,
    input  logic [7:0]  i_data,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    output logic        o_run,
    output logic        o_err
);

    localparam int TW = $clog2(p_timeout + 1);
    localparam logic [TW-1:0] TIMEOUT_VAL = TW'(p_timeout);

`ifdef X_TOP_UART_LOADER_CSUM_EN
    typedef enum logic [2:0] {IDLE, ADDR, DATA, CSUM, WRITE} state_t;
`else
    typedef enum logic [2:0] {IDLE, ADDR, DATA, WRITE} state_t;
`endif

    state_t        state_reg, state_next;
    logic [1:0]    cnt_reg, cnt_next;
    logic [TW-1:0] timer_reg, timer_next;
    logic [31:0]   addr_reg, addr_next;
    logic [31:0]   wdata_reg, wdata_next;
    logic          valid_reg, valid_next;
    logic          run_reg, run_next;
    logic          err_reg, err_next;
`ifdef X_TOP_UART_LOADER_CSUM_EN
    logic [7:0]    csum_reg, csum_next;
`endif

    logic timeout;
    logic timed_state;

    // A byte arriving in the same cycle always beats the timeout.
    assign timeout = (timer_reg == TIMEOUT_VAL) && !i_valid;

`ifdef X_TOP_UART_LOADER_CSUM_EN
    assign timed_state = (state_reg == ADDR) || (state_reg == DATA) || (state_reg == CSUM);
`else
    assign timed_state = (state_reg == ADDR) || (state_reg == DATA);
`endif

    // State and datapath registers; async reset drops the write request at once.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
            timer_reg <= '0;
            addr_reg  <= 32'd0;
            wdata_reg <= 32'd0;
            valid_reg <= 1'b0;
            run_reg   <= 1'b0;
            err_reg   <= 1'b0;
`ifdef X_TOP_UART_LOADER_CSUM_EN
            csum_reg  <= 8'd0;
`endif
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            timer_reg <= timer_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
            valid_reg <= valid_next;
            run_reg   <= run_next;
            err_reg   <= err_next;
`ifdef X_TOP_UART_LOADER_CSUM_EN
            csum_reg  <= csum_next;
`endif
        end
    end

    // Next-state, byte assembly, flag and timer logic.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        run_next   = run_reg;
        err_next   = err_reg;
`ifdef X_TOP_UART_LOADER_CSUM_EN
        csum_next  = csum_reg;
`endif

        case (state_reg)
            IDLE: begin
                if (i_valid) begin
                    if (i_data == 8'h57) begin
                        state_next = ADDR;
                        cnt_next   = 2'd0;
`ifdef X_TOP_UART_LOADER_CSUM_EN
                        csum_next  = 8'd0;
`endif
                    end else if (i_data == 8'h47) begin
                        run_next = 1'b1;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            ADDR: begin
                if (i_valid) begin
                    // Shifting in from the top leaves the first byte in [7:0].
                    addr_next = {i_data, addr_reg[31:8]};
                    cnt_next  = cnt_reg + 2'd1;
`ifdef X_TOP_UART_LOADER_CSUM_EN
                    csum_next = csum_reg ^ i_data;
`endif
                    if (cnt_reg == 2'd3) begin
                        state_next = DATA;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
            DATA: begin
                if (i_valid) begin
                    wdata_next = {i_data, wdata_reg[31:8]};
                    cnt_next   = cnt_reg + 2'd1;
`ifdef X_TOP_UART_LOADER_CSUM_EN
                    csum_next  = csum_reg ^ i_data;
`endif
                    if (cnt_reg == 2'd3) begin
`ifdef X_TOP_UART_LOADER_CSUM_EN
                        state_next = CSUM;
`else
                        state_next = WRITE;
`endif
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`ifdef X_TOP_UART_LOADER_CSUM_EN
            CSUM: begin
                if (i_valid) begin
                    if (i_data == csum_reg) begin
                        state_next = WRITE;
                    end else begin
                        state_next = IDLE;
                        err_next   = 1'b1;
                    end
                end else if (timeout) begin
                    state_next = IDLE;
                    err_next   = 1'b1;
                end
            end
`endif
            WRITE: begin
                // No backpressure upstream: a byte arriving now is lost.
                if (i_valid) begin
                    err_next = 1'b1;
                end
                if (i_mem_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Timer restarts on any byte or state change and saturates at the limit.
        timer_next = '0;
        if (timed_state && !i_valid && (state_next == state_reg)) begin
            if (timer_reg < TIMEOUT_VAL) begin
                timer_next = timer_reg + TW'(1);
            end else begin
                timer_next = timer_reg;
            end
        end

        // Registered request keeps every output flop-driven.
        valid_next = (state_next == WRITE);
    end

    assign o_mem_valid = valid_reg;
    assign o_mem_addr  = {addr_reg[31:2], 2'b00};
    assign o_mem_wdata = wdata_reg;
    assign o_run       = run_reg;
    assign o_err       = err_reg;

endmodule

// File: tb/tb_x_top_uart_loader.sv
// Directed testbench for x_top_uart_loader (p_timeout = 16).
module tb_x_top_uart_loader;

    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        mem_ready = 1'b1;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        run;
    logic        err;

    x_top_uart_loader #(.p_timeout(16)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_valid     (valid),
        .i_data      (data),
        .o_mem_valid (mem_valid),
        .i_mem_ready (mem_ready),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_run       (run),
        .o_err       (err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    // Write-port monitor: samples just after the falling edge, when inputs for
    // the coming rising edge are settled.
    int          hs_cnt = 0;
    int          vcnt = 0;
    int          unstable = 0;
    logic [31:0] hs_addr = 32'd0;
    logic [31:0] hs_data = 32'd0;
    logic [31:0] prev_addr = 32'd0;
    logic [31:0] prev_data = 32'd0;
    logic        in_write = 1'b0;

    always begin
        @(negedge clk);
        #1;
        if (mem_valid) begin
            vcnt++;
            if (in_write && (mem_addr !== prev_addr || mem_wdata !== prev_data)) unstable++;
            prev_addr = mem_addr;
            prev_data = mem_wdata;
            in_write  = 1'b1;
            if (mem_ready) begin
                hs_cnt++;
                hs_addr = mem_addr;
                hs_data = mem_wdata;
                $display("write addr=%08h data=%08h", mem_addr, mem_wdata);
            end
        end else begin
            in_write = 1'b0;
        end
    end

    // All tasks start and end on a falling edge.
    task automatic send(input logic [7:0] b);
        valid = 1'b1;
        data  = b;
        @(negedge clk);
    endtask

    task automatic send_body(input logic [31:0] a, input logic [31:0] d);
        send(8'h57);
        for (int i = 0; i < 4; i++) send(a[8*i +: 8]);
        for (int i = 0; i < 4; i++) send(d[8*i +: 8]);
    endtask

`ifdef X_TOP_UART_LOADER_CSUM_EN
    task automatic send_csum(input logic [31:0] a, input logic [31:0] d, input bit good);
        logic [7:0] cs;
        cs = 8'd0;
        for (int i = 0; i < 4; i++) cs = cs ^ a[8*i +: 8] ^ d[8*i +: 8];
        send(good ? cs : 8'h00);
    endtask
`endif

    task automatic frame(input logic [31:0] a, input logic [31:0] d);
        send_body(a, d);
`ifdef X_TOP_UART_LOADER_CSUM_EN
        send_csum(a, d, 1'b1);
`endif
        valid = 1'b0;
    endtask

    task automatic do_reset;
        valid = 1'b0;
        nrst  = 1'b0;
        repeat (2) @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
    endtask

    int b0;
    int v0;
    int u0;

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, mem_valid}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_run", {31'd0, run}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        nrst = 1'b1;
        @(negedge clk);

        // Basic frame, ready tied high: one single-cycle write
        mem_ready = 1'b1;
        b0 = hs_cnt; v0 = vcnt;
        frame(32'h0000_0010, 32'hDEAD_BEEF);
        chk("t1_valid_rise", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        chk("t1_valid_fall", {31'd0, mem_valid}, 32'd0);
        repeat (3) @(negedge clk);
        chk("t1_hs", hs_cnt - b0, 32'd1);
        chk("t1_vcycles", vcnt - v0, 32'd1);
        chk("t1_addr", hs_addr, 32'h0000_0010);
        chk("t1_data", hs_data, 32'hDEAD_BEEF);
        chk("t1_err", {31'd0, err}, 32'd0);

        // Ready low for 5 cycles, stray byte during the wait
        mem_ready = 1'b0;
        b0 = hs_cnt; v0 = vcnt; u0 = unstable;
        frame(32'h0000_0010, 32'hDEAD_BEEF);
        chk("t2_valid_rise", {31'd0, mem_valid}, 32'd1);
        @(negedge clk);
        send(8'h55);
        valid = 1'b0;
        chk("t2_err_rise", {31'd0, err}, 32'd1);
        chk("t2_valid_held", {31'd0, mem_valid}, 32'd1);
        repeat (3) @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t2_valid_fall", {31'd0, mem_valid}, 32'd0);
        repeat (2) @(negedge clk);
        chk("t2_hs", hs_cnt - b0, 32'd1);
        chk("t2_vcycles", vcnt - v0, 32'd6);
        chk("t2_stable", unstable - u0, 32'd0);
        chk("t2_addr", hs_addr, 32'h0000_0010);
        chk("t2_data", hs_data, 32'hDEAD_BEEF);
        chk("t2_err", {31'd0, err}, 32'd1);

        // Go command and unknown command
        do_reset();
        chk("t3_run_init", {31'd0, run}, 32'd0);
        send(8'h47);
        valid = 1'b0;
        chk("t3_run_set", {31'd0, run}, 32'd1);
        chk("t3_err_clear", {31'd0, err}, 32'd0);
        @(negedge clk);
        send(8'h47);
        valid = 1'b0;
        chk("t3_run_keep", {31'd0, run}, 32'd1);
        send(8'h00);
        valid = 1'b0;
        chk("t3_err_set", {31'd0, err}, 32'd1);
        chk("t3_run_sticky", {31'd0, run}, 32'd1);

        // Timeout in DATA, then a good frame with 'W'/'G' as data
        do_reset();
        b0 = hs_cnt;
        send(8'h57); send(8'h13); send(8'h00); send(8'h00); send(8'h00);
        valid = 1'b0;
        repeat (16) @(negedge clk);
        chk("t4_err_before", {31'd0, err}, 32'd0);
        @(negedge clk);
        chk("t4_err_timeout", {31'd0, err}, 32'd1);
        @(negedge clk);
        chk("t4_no_write", hs_cnt - b0, 32'd0);
        frame(32'h0000_0023, 32'h1234_4757);
        repeat (3) @(negedge clk);
        chk("t4_hs", hs_cnt - b0, 32'd1);
        chk("t4_addr", hs_addr, 32'h0000_0020);
        chk("t4_data", hs_data, 32'h1234_4757);
        chk("t4_run", {31'd0, run}, 32'd0);

        // Wrong checksum byte (only present when checksum is enabled)
        do_reset();
        b0 = hs_cnt;
        send_body(32'h0000_0010, 32'hDEAD_BEEF);
`ifdef X_TOP_UART_LOADER_CSUM_EN
        send_csum(32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
`endif
        valid = 1'b0;
        repeat (3) @(negedge clk);
`ifdef X_TOP_UART_LOADER_CSUM_EN
        chk("t5_hs", hs_cnt - b0, 32'd0);
        chk("t5_err", {31'd0, err}, 32'd1);
`else
        chk("t5_hs", hs_cnt - b0, 32'd1);
        chk("t5_err", {31'd0, err}, 32'd0);
`endif

        // Reset asserted while in WRITE
        mem_ready = 1'b0;
        frame(32'h0000_0044, 32'hCAFE_F00D);
        chk("t6_in_write", {31'd0, mem_valid}, 32'd1);
        #2;
        nrst = 1'b0;
        #1;
        chk("t6_async_drop", {31'd0, mem_valid}, 32'd0);
        @(negedge clk);
        nrst = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("t6_run", {31'd0, run}, 32'd0);
        chk("t6_err", {31'd0, err}, 32'd0);
        chk("t6_addr_rst", mem_addr, 32'd0);
        b0 = hs_cnt;
        frame(32'h0000_0048, 32'h0102_0304);
        repeat (3) @(negedge clk);
        chk("t6_hs", hs_cnt - b0, 32'd1);
        chk("t6_addr", hs_addr, 32'h0000_0048);
        chk("t6_data", hs_data, 32'h0102_0304);
        chk("t6_err_after", {31'd0, err}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
